jtframe_rom_arbiter: RTL and testbench

Responder side of the per-slot ROM request handshake: collects `req`/`sdram_addr` from several ROM request clients, serves one at a time through a 16-bit burst-read SDRAM controller port, and returns a 32-bit word with the per-slot `we` select and a `din_ok` strobe. It sits between the game's ROM request slots and the SDRAM controller, one instance per SDRAM bank.

---
 rtl/jtframe_rom_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_jtframe_rom_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_arbiter.sv
// Round-robin ROM request arbiter: serves one client slot at a time through a 2-beat 16-bit SDRAM burst read.
// Optional watchdog on stalled accesses is enabled with the JTFRAME_ROMARB_TIMEOUT_EN macro.
module jtframe_rom_arbiter #(
    parameter int SLOTS = 4,
    parameter int TOW   = 8
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic [SLOTS-1:0]      slot_req,
    input  logic [SLOTS*22-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_we,
    output logic [31:0]           slot_din,
    output logic                  slot_din_ok,
    output logic                  sdram_rd,
    output logic [21:0]           sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  sdram_dst,
    input  logic [15:0]           sdram_data,
    output logic                  busy,
    output logic                  err
);
    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_W1   = 3'd2,
        ST_W2   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               rd_q, rd_d;
    logic [21:0]        addr_q, addr_d;
    logic [SLOTS-1:0]   we_q, we_d;
    logic [31:0]        din_q, din_d;
    logic               ok_q, ok_d;
    logic               gnt_found_s;
    logic [PW-1:0]      gnt_idx_s;
    logic               timeout_s;
    logic               to_fire_s;

    // Round-robin search starting at the slot after the last grant
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = ptr_q;
        for (int i = 1; i <= SLOTS; i++) begin
            if (!gnt_found_s && slot_req[(int'(ptr_q) + i) % SLOTS]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = PW'((int'(ptr_q) + i) % SLOTS);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Watchdog fires only when the awaited controller event did not arrive this cycle
    always_comb begin
        case (state_q)
            ST_REQ:         to_fire_s = timeout_s && !sdram_ack;
            ST_W1, ST_W2:   to_fire_s = timeout_s && !sdram_dst;
            default:        to_fire_s = 1'b0;
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(SLOTS - 1);
            rd_q    <= 1'b0;
            addr_q  <= 22'd0;
            we_q    <= {SLOTS{1'b0}};
            din_q   <= 32'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            ok_q    <= ok_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = gnt_found_s ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                if (sdram_ack)      state_d = ST_W1;
                else if (to_fire_s) state_d = ST_DONE;
                else                state_d = ST_REQ;
            end
            ST_W1: begin
                if (sdram_dst)      state_d = ST_W2;
                else if (to_fire_s) state_d = ST_DONE;
                else                state_d = ST_W1;
            end
            ST_W2: begin
                if (sdram_dst || to_fire_s) state_d = ST_DONE;
                else                        state_d = ST_W2;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register next values
    always_comb begin
        ptr_d  = ptr_q;
        rd_d   = rd_q;
        addr_d = addr_q;
        we_d   = we_q;
        din_d  = din_q;
        ok_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    ptr_d  = gnt_idx_s;
                    rd_d   = 1'b1;
                    addr_d = slot_addr[int'(gnt_idx_s) * 22 +: 22];
                    we_d   = {{(SLOTS-1){1'b0}}, 1'b1} << gnt_idx_s;
                end else begin
                    we_d   = {SLOTS{1'b0}};
                end
            end
            ST_REQ: begin
                if (sdram_ack || to_fire_s) rd_d = 1'b0;
                else                        rd_d = 1'b1;
            end
            ST_W1: begin
                if (sdram_dst) din_d[15:0] = sdram_data;
                else           din_d       = din_q;
            end
            ST_W2: begin
                if (sdram_dst) begin
                    din_d[31:16] = sdram_data;
                    ok_d         = 1'b1;
                end else begin
                    din_d        = din_q;
                end
            end
            ST_DONE: we_d = {SLOTS{1'b0}};
            default: we_d = {SLOTS{1'b0}};
        endcase
        if (to_fire_s) begin
            rd_d  = 1'b0;
            din_d = 32'hFFFF_FFFF;
            ok_d  = 1'b1;
        end else begin
            ok_d  = ok_d;
        end
    end

`ifdef JTFRAME_ROMARB_TIMEOUT_EN
    logic [TOW-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;

    assign timeout_s = (cnt_q == {TOW{1'b1}});

    // Counter restarts at grant and at every accepted beat
    always_comb begin
        err_d = err_q | to_fire_s;
        case (state_q)
            ST_REQ:         cnt_d = cnt_q + {{(TOW-1){1'b0}}, 1'b1};
            ST_W1, ST_W2:   cnt_d = sdram_dst ? {TOW{1'b0}} : cnt_q + {{(TOW-1){1'b0}}, 1'b1};
            default:        cnt_d = {TOW{1'b0}};
        endcase
    end

    // Watchdog registers; err is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {TOW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0 & (TOW > 0);
`endif

    assign busy        = (state_q != ST_IDLE);
    assign sdram_rd    = rd_q;
    assign sdram_addr  = addr_q;
    assign slot_we     = we_q;
    assign slot_din    = din_q;
    assign slot_din_ok = ok_q;
endmodule

// File: tb/tb_jtframe_rom_arbiter.sv
// Directed self-checking bench for jtframe_rom_arbiter (SLOTS=4, TOW=4).
module tb_jtframe_rom_arbiter;
    logic          rst;
    logic          clk = 1'b0;
    logic [3:0]    slot_req;
    logic [87:0]   slot_addr;
    logic [3:0]    slot_we;
    logic [31:0]   slot_din;
    logic          slot_din_ok;
    logic          sdram_rd;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          sdram_dst;
    logic [15:0]   sdram_data;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    jtframe_rom_arbiter #(.SLOTS(4), .TOW(4)) dut (
        .rst         (rst),
        .clk         (clk),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_we     (slot_we),
        .slot_din    (slot_din),
        .slot_din_ok (slot_din_ok),
        .sdram_rd    (sdram_rd),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .sdram_dst   (sdram_dst),
        .sdram_data  (sdram_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_addr(input int n, input logic [21:0] a);
        slot_addr[n*22 +: 22] = a;
    endtask

    // Starts in the IDLE cycle that grants; ends at the following IDLE cycle
    task automatic serve(input int s, input logic [21:0] a, input logic [15:0] d0, input logic [15:0] d1);
        tick();
        chk("req_rd",   32'(sdram_rd), 32'd1);
        chk("req_we",   32'(slot_we), 32'd1 << s);
        chk("req_addr", 32'(sdram_addr), 32'(a));
        chk("req_busy", 32'(busy), 32'd1);
        sdram_ack = 1'b1;
        tick();
        chk("w1_rd", 32'(sdram_rd), 32'd0);
        sdram_ack  = 1'b0;
        sdram_dst  = 1'b1;
        sdram_data = d0;
        tick();
        sdram_data = d1;
        tick();
        sdram_dst = 1'b0;
        chk("done_ok",  32'(slot_din_ok), 32'd1);
        chk("done_din", slot_din, {d1, d0});
        chk("done_we",  32'(slot_we), 32'd1 << s);
        tick();
        chk("idle_ok", 32'(slot_din_ok), 32'd0);
        chk("idle_we", 32'(slot_we), 32'd0);
    endtask

    initial begin
        logic [21:0] rr_addr [4];
        int          rr_seq  [5];
        rr_addr = '{22'h000A0, 22'h000B1, 22'h000C2, 22'h000D3};
        rr_seq  = '{0, 1, 2, 3, 0};

        rst        = 1'b1;
        slot_req   = 4'b0000;
        slot_addr  = 88'd0;
        sdram_ack  = 1'b0;
        sdram_dst  = 1'b0;
        sdram_data = 16'h0000;
        tick();
        tick();
        chk("rst_rd",   32'(sdram_rd), 32'd0);
        chk("rst_we",   32'(slot_we), 32'd0);
        chk("rst_din",  slot_din, 32'd0);
        chk("rst_ok",   32'(slot_din_ok), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Single read from slot 2
        set_addr(2, 22'h01234);
        slot_req = 4'b0100;
        serve(2, 22'h01234, 16'hBEEF, 16'hDEAD);
        slot_req = 4'b0000;
        chk("single_hold", slot_din, 32'hDEADBEEF);
        chk("single_busy", 32'(busy), 32'd0);

        // Round-robin after reset, all slots requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) set_addr(n, rr_addr[n]);
        slot_req = 4'b1111;
        for (int k = 0; k < 5; k++)
            serve(rr_seq[k], rr_addr[rr_seq[k]], 16'(16'h1000 + k), 16'(16'h2000 + k));
        slot_req = 4'b0000;
        tick();
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Controller stall: slot 3, ack late with a dst in the same cycle, gapped beats
        set_addr(3, 22'h3ABCD);
        slot_req = 4'b1000;
        tick();
        slot_req = 4'b0000;
        chk("stall_we", 32'(slot_we), 32'b1000);
        for (int c = 1; c <= 5; c++) begin
            chk("stall_rd_hold", 32'(sdram_rd), 32'd1);
            tick();
        end
        chk("stall_rd_6", 32'(sdram_rd), 32'd1);
        sdram_ack  = 1'b1;
        sdram_dst  = 1'b1;
        sdram_data = 16'h9999;
        tick();
        chk("stall_rd_drop", 32'(sdram_rd), 32'd0);
        sdram_ack  = 1'b0;
        sdram_data = 16'h1111;
        tick();
        sdram_dst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_gap_ok", 32'(slot_din_ok), 32'd0);
            tick();
        end
        sdram_dst  = 1'b1;
        sdram_data = 16'h2222;
        tick();
        sdram_dst = 1'b0;
        chk("stall_ok",  32'(slot_din_ok), 32'd1);
        chk("stall_din", slot_din, 32'h2222_1111);
        tick();
        sdram_dst  = 1'b1;
        sdram_data = 16'h5555;
        tick();
        sdram_dst = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_din",  slot_din, 32'h2222_1111);
        chk("stray_ok",   32'(slot_din_ok), 32'd0);

        // Request drop in W1: slot 1
        set_addr(1, 22'h00777);
        slot_req = 4'b0010;
        tick();
        chk("drop_we", 32'(slot_we), 32'b0010);
        sdram_ack = 1'b1;
        tick();
        sdram_ack  = 1'b0;
        slot_req   = 4'b0000;
        sdram_dst  = 1'b1;
        sdram_data = 16'h0A0A;
        tick();
        sdram_data = 16'h0B0B;
        tick();
        sdram_dst = 1'b0;
        chk("drop_ok",  32'(slot_din_ok), 32'd1);
        chk("drop_we2", 32'(slot_we), 32'b0010);
        chk("drop_din", slot_din, 32'h0B0B_0A0A);
        tick();
        tick();
        chk("drop_no_regrant", 32'(sdram_rd), 32'd0);
        chk("drop_idle",       32'(busy), 32'd0);

        // Reset asserted while in W2
        set_addr(2, 22'h02222);
        slot_req = 4'b0100;
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack  = 1'b0;
        sdram_dst  = 1'b1;
        sdram_data = 16'hAAAA;
        tick();
        sdram_dst = 1'b0;
        chk("w2_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd",   32'(sdram_rd), 32'd0);
        chk("mid_rst_we",   32'(slot_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_din",  slot_din, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_addr(0, 22'h00042);
        slot_req = 4'b0101;
        serve(0, 22'h00042, 16'h4321, 16'h8765);
        slot_req = 4'b0000;
        tick();

`ifdef JTFRAME_ROMARB_TIMEOUT_EN
        // Watchdog: ack then no beats
        slot_req = 4'b0001;
        tick();
        slot_req  = 4'b0000;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            chk("to_wait_ok", 32'(slot_din_ok), 32'd0);
            tick();
        end
        chk("to_ok",  32'(slot_din_ok), 32'd1);
        chk("to_din", slot_din, 32'hFFFF_FFFF);
        chk("to_err", 32'(err), 32'd1);
        tick();
        tick();
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_idle",       32'(busy), 32'd0);
`else
        chk("err_tied", 32'(err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
